apb_gpio_irq: RTL

//  Second-generation APB GPIO peripheral: N_GPIOS pins, each with direction, inversion, 2-FF input sync,
//  per-pin debounce, four interrupt modes and a sticky W1C status. Sits on the APB peripheral bus.
//  Per-pin irq_o plus combined irq_comb_o feed the interrupt controller.

---
 rtl/gpio_pkg.sv | 42 ++++
 rtl/apb_bus_t.sv | 23 ++
 rtl/gpio_dbnc.sv | 83 ++++++++
 rtl/apb_gpio_irq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO peripheral: register map indices,
// interrupt mode encoding and the per-pin event decoder.
package gpio_pkg;

    localparam int unsigned GPIO_MAX_PINS = 32;
    localparam int unsigned GPIO_IDX_W    = 4;

    localparam logic [GPIO_IDX_W-1:0] GPIO_DIR        = 4'd0;
    localparam logic [GPIO_IDX_W-1:0] GPIO_OUT        = 4'd1;
    localparam logic [GPIO_IDX_W-1:0] GPIO_IN         = 4'd2;
    localparam logic [GPIO_IDX_W-1:0] GPIO_INV        = 4'd3;
    localparam logic [GPIO_IDX_W-1:0] GPIO_INT_EN     = 4'd4;
    localparam logic [GPIO_IDX_W-1:0] GPIO_INT_T0     = 4'd5;
    localparam logic [GPIO_IDX_W-1:0] GPIO_INT_T1     = 4'd6;
    localparam logic [GPIO_IDX_W-1:0] GPIO_INT_STATUS = 4'd7;
    localparam logic [GPIO_IDX_W-1:0] GPIO_DBNC_CFG   = 4'd8;
    localparam logic [GPIO_IDX_W-1:0] GPIO_OUT_SET    = 4'd9;
    localparam logic [GPIO_IDX_W-1:0] GPIO_OUT_CLR    = 4'd10;

    // Mode encoding is {INT_T1, INT_T0}
    typedef enum logic [1:0] {
        INT_RISE  = 2'b00,
        INT_FALL  = 2'b01,
        INT_EDGE  = 2'b10,
        INT_LEVEL = 2'b11
    } gpio_int_mode_e;

    function automatic logic int_event(input gpio_int_mode_e mode,
                                       input logic prev, input logic stable);
        logic ev;
        ev = 1'b0;
        case (mode)
            INT_RISE:  ev = ~prev & stable;
            INT_FALL:  ev = prev & ~stable;
            INT_EDGE:  ev = prev ^ stable;
            INT_LEVEL: ev = stable;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/apb_bus_t.sv
// APB peripheral bus bundle; clock and active-low async reset travel with it.
interface apb_bus_t (
    input logic PCLK,
    input logic PRESETn
);
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport slave (
        input  PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

    modport master (
        input  PCLK, PRESETn, PRDATA, PREADY,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/gpio_dbnc.sv
// One input pin: 2-FF sync with inversion, debounce to a stable level, previous level.
// Counter logic exists only when GPIO_DBNC_EN is defined; otherwise stable follows s2.
module gpio_dbnc #(
    parameter int unsigned DBNC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pin_i,
    input  logic              inv_i,
    input  logic [DBNC_W-1:0] thr_i,
    output logic              stable_o,
    output logic              prev_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic stable_q, stable_d;
    logic prev_q, prev_d;

`ifdef GPIO_DBNC_EN
    localparam int unsigned CW = DBNC_W + 1;

    logic [DBNC_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]     thr_eff;
    logic [CW-1:0]     cnt_nxt;

    // A threshold of 0 behaves as 1; stable commits on the T-th mismatching cycle
    always_comb begin
        s1_d     = pin_i ^ inv_i;
        s2_d     = s1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = '0;
        thr_eff  = (thr_i == '0) ? CW'(1) : {1'b0, thr_i};
        cnt_nxt  = {1'b0, cnt_q} + CW'(1);
        if (s2_q != stable_q) begin
            if (cnt_nxt >= thr_eff) begin
                stable_d = s2_q;
            end else if (&cnt_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_nxt[DBNC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^thr_i;

    always_comb begin
        s1_d     = pin_i ^ inv_i;
        s2_d     = s1_q;
        prev_d   = stable_q;
        stable_d = s2_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
        end
    end

    assign stable_o = stable_q;
    assign prev_o   = prev_q;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB GPIO with per-pin direction, inversion, debounced inputs and sticky W1C interrupts.
// Define GPIO_DBNC_EN to build the debounce counters and the DBNC_CFG register.
module apb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned N_GPIOS = 8,
    parameter int unsigned DBNC_W  = 8
) (
    apb_bus_t.slave             apb_bus,
    output logic [N_GPIOS-1:0]  dir_o,
    output logic [N_GPIOS-1:0]  val_o,
    input  logic [N_GPIOS-1:0]  val_i,
    output logic [N_GPIOS-1:0]  irq_o,
    output logic                irq_comb_o
);

    logic                  clk;
    logic                  rst_n;
    logic                  access;
    logic                  wr_en;
    logic [GPIO_IDX_W-1:0] idx;
    logic [N_GPIOS-1:0]    wdata;
    logic [31:0]           rdata;
    logic                  unused_apb;

    logic [N_GPIOS-1:0] dir_q, dir_d;
    logic [N_GPIOS-1:0] out_q, out_d;
    logic [N_GPIOS-1:0] inv_q, inv_d;
    logic [N_GPIOS-1:0] int_en_q, int_en_d;
    logic [N_GPIOS-1:0] int_t0_q, int_t0_d;
    logic [N_GPIOS-1:0] int_t1_q, int_t1_d;
    logic [N_GPIOS-1:0] status_q, status_d;
    logic [N_GPIOS-1:0] val_q, val_d;
    logic               irq_comb_q, irq_comb_d;
    logic [N_GPIOS-1:0] w1c;
    logic [N_GPIOS-1:0] ev;
    logic [N_GPIOS-1:0] stable;
    logic [N_GPIOS-1:0] prev;
    logic [DBNC_W-1:0]  thr;

    assign clk        = apb_bus.PCLK;
    assign rst_n      = apb_bus.PRESETn;
    assign access     = apb_bus.PSEL & apb_bus.PENABLE & rst_n;
    assign wr_en      = access & apb_bus.PWRITE;
    assign idx        = apb_bus.PADDR[5:2];
    assign wdata      = apb_bus.PWDATA[N_GPIOS-1:0];
    assign unused_apb = ^{apb_bus.PADDR[31:6], apb_bus.PADDR[1:0], apb_bus.PWDATA};

`ifdef GPIO_DBNC_EN
    logic [DBNC_W-1:0] dbnc_cfg_q, dbnc_cfg_d;

    always_comb begin
        dbnc_cfg_d = dbnc_cfg_q;
        if (wr_en && idx == GPIO_DBNC_CFG) begin
            dbnc_cfg_d = apb_bus.PWDATA[DBNC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbnc_cfg_q <= '0;
        end else begin
            dbnc_cfg_q <= dbnc_cfg_d;
        end
    end

    assign thr = dbnc_cfg_q;
`else
    assign thr = '0;
`endif

    for (genvar i = 0; i < N_GPIOS; i++) begin : g_pin
        gpio_dbnc #(.DBNC_W(DBNC_W)) u_dbnc (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin_i    (val_i[i]),
            .inv_i    (inv_q[i]),
            .thr_i    (thr),
            .stable_o (stable[i]),
            .prev_o   (prev[i])
        );
    end

    // Register writes, event detection and sticky status (a new event beats W1C)
    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        inv_d    = inv_q;
        int_en_d = int_en_q;
        int_t0_d = int_t0_q;
        int_t1_d = int_t1_q;
        w1c      = '0;
        ev       = '0;
        for (int i = 0; i < N_GPIOS; i++) begin
            ev[i] = ~dir_q[i] & int_en_q[i] &
                    int_event(gpio_int_mode_e'({int_t1_q[i], int_t0_q[i]}), prev[i], stable[i]);
        end
        if (wr_en) begin
            case (idx)
                GPIO_DIR:        dir_d    = wdata;
                GPIO_OUT:        out_d    = wdata;
                GPIO_INV:        inv_d    = wdata;
                GPIO_INT_EN:     int_en_d = wdata;
                GPIO_INT_T0:     int_t0_d = wdata;
                GPIO_INT_T1:     int_t1_d = wdata;
                GPIO_INT_STATUS: w1c      = wdata;
                GPIO_OUT_SET:    out_d    = out_q | wdata;
                GPIO_OUT_CLR:    out_d    = out_q & ~wdata;
                default:         ;
            endcase
        end
        status_d   = (status_q & ~w1c) | ev;
        val_d      = dir_d & (out_d ^ inv_d);
        irq_comb_d = |status_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            inv_q      <= '0;
            int_en_q   <= '0;
            int_t0_q   <= '0;
            int_t1_q   <= '0;
            status_q   <= '0;
            val_q      <= '0;
            irq_comb_q <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            inv_q      <= inv_d;
            int_en_q   <= int_en_d;
            int_t0_q   <= int_t0_d;
            int_t1_q   <= int_t1_d;
            status_q   <= status_d;
            val_q      <= val_d;
            irq_comb_q <= irq_comb_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            GPIO_DIR:        rdata = 32'(dir_q);
            GPIO_OUT:        rdata = 32'(out_q);
            GPIO_IN:         rdata = 32'(stable);
            GPIO_INV:        rdata = 32'(inv_q);
            GPIO_INT_EN:     rdata = 32'(int_en_q);
            GPIO_INT_T0:     rdata = 32'(int_t0_q);
            GPIO_INT_T1:     rdata = 32'(int_t1_q);
            GPIO_INT_STATUS: rdata = 32'(status_q);
`ifdef GPIO_DBNC_EN
            GPIO_DBNC_CFG:   rdata = 32'(dbnc_cfg_q);
`endif
            default:         rdata = '0;
        endcase
    end

    assign apb_bus.PREADY = access;
    assign apb_bus.PRDATA = access ? rdata : '0;

    assign dir_o      = dir_q;
    assign val_o      = val_q;
    assign irq_o      = status_q;
    assign irq_comb_o = irq_comb_q;

endmodule
